// File: rtl/mux_gate_scheduler_if.sv
// rtl/mux_gate_scheduler_if.sv - request/result bundle for the shared mux-gate evaluator
interface mux_gate_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_err;
    logic             busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        output res_ready,
        input  res_valid, res_data, res_id, res_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        input  res_ready,
        output res_valid, res_data, res_id, res_err, busy
    );
endinterface

// File: rtl/mux_gate_scheduler.sv
// rtl/mux_gate_scheduler.sv - round-robin scheduler around a bit-serial 2:1-mux gate evaluator
module mux_gate_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux_gate_scheduler_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             res_err_q;
    logic             last_id;

    logic             grant;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic [2:0]       acc_op;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_b;

    logic             a_bit;
    logic             b_bit;
    logic             sel;
    logic             i0;
    logic             i1;
    logic             bit_val;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_id;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign ready0 = !rst && (state == IDLE) && bus.req0_valid && !grant;
    assign ready1 = !rst && (state == IDLE) && bus.req1_valid && grant;
    assign accept = ready0 || ready1;
    assign acc_op = ready1 ? bus.req1_op : bus.req0_op;
    assign acc_a  = ready1 ? bus.req1_a  : bus.req0_a;
    assign acc_b  = ready1 ? bus.req1_b  : bus.req0_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (cnt == LAST) state_next = DONE;
            DONE:    if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign a_bit = a_q[cnt];
    assign b_bit = b_q[cnt];

    // Every legal gate is one 2:1 mux; opcode 7 selects constant zero.
    always_comb begin
        sel = 1'b0;
        i0  = 1'b0;
        i1  = 1'b0;
        case (op_q)
            3'd0: begin sel = b_bit; i0 = 1'b0;   i1 = a_bit;  end
            3'd1: begin sel = b_bit; i0 = a_bit;  i1 = 1'b1;   end
            3'd2: begin sel = a_bit; i0 = 1'b1;   i1 = 1'b0;   end
            3'd3: begin sel = a_bit; i0 = 1'b1;   i1 = ~b_bit; end
            3'd4: begin sel = a_bit; i0 = ~b_bit; i1 = 1'b0;   end
            3'd5: begin sel = a_bit; i0 = b_bit;  i1 = ~b_bit; end
            3'd6: begin sel = a_bit; i0 = ~b_bit; i1 = b_bit;  end
            default: ;
        endcase
        bit_val = sel ? i1 : i0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            last_id    <= 1'b1;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
        end else if (accept) begin
            op_q       <= acc_op;
            a_q        <= acc_a;
            b_q        <= acc_b;
            cnt        <= '0;
            last_id    <= ready1;
            res_data_q <= '0;
            res_id_q   <= ready1;
            res_err_q  <= (acc_op == 3'd7);
        end else if (state == EXEC) begin
            res_data_q[cnt] <= bit_val;
            if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = (state == DONE);
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_err    = res_err_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mux_gate_scheduler.sv
// tb/tb_mux_gate_scheduler.sv - self-checking bench for mux_gate_scheduler
`timescale 1ns/1ps
module tb_mux_gate_scheduler;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_gate_scheduler_if #(.WIDTH(W)) bus ();
    mux_gate_scheduler #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic         id;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic set_req(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic wait_accept(output logic id, output bit ok);
        ok = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (bus.req0_valid && bus.req0_ready) begin ok = 1'b1; id = 1'b0; end
            else if (bus.req1_valid && bus.req1_ready) begin ok = 1'b1; id = 1'b1; end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_result(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.res_valid) ok = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!ok) check("result_timeout", 0, 1);
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic do_txn(input string tag, input vec_t v);
        logic gid;
        bit   ok;
        int   lat;
        set_req(v.id, v.op, v.a, v.b);
        wait_accept(gid, ok);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check({tag, "_grant"}, gid, v.id);
        wait_result(lat);
        check({tag, "_latency"}, lat, W);
        check({tag, "_data"}, bus.res_data, v.exp_data);
        check({tag, "_id"}, bus.res_id, v.id);
        check({tag, "_err"}, bus.res_err, v.exp_err);
        take_result();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         gid;
        bit           ok;
        int           lat;
        int           acc_cyc[4];
        logic         acc_id[4];
        int           n_acc;
        logic [W-1:0] hold;
        bit           seen;
        logic         last;
        logic         exp_id;
        int           v;
        logic [2:0]   op0, op1, wop;
        logic [W-1:0] a0, a1, b0, b1, wa, wb;

        vecs[0] = '{1'b0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{1'b1, 3'd5, 8'hA5, 8'hFF, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 3'd2, 8'hA5, 8'h00, 8'h5A, 1'b0};
        vecs[3] = '{1'b1, 3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0};
        vecs[4] = '{1'b1, 3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[5] = '{1'b1, 3'd4, 8'h0F, 8'h30, 8'hC0, 1'b0};
        vecs[6] = '{1'b1, 3'd1, 8'h0F, 8'h30, 8'h3F, 1'b0};
        vecs[7] = '{1'b0, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};

        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready  = 1'b0;
        @(negedge clk);
        do_reset();
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

        // Fairness: both valid from reset, consumer always ready.
        do_reset();
        set_req(1'b0, 3'd0, 8'h11, 8'hFF);
        set_req(1'b1, 3'd0, 8'h22, 8'hFF);
        bus.res_ready = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (n_acc < 4 && bus.req0_valid && bus.req0_ready) begin acc_cyc[n_acc] = cyc; acc_id[n_acc] = 1'b0; n_acc++; end
            else if (n_acc < 4 && bus.req1_valid && bus.req1_ready) begin acc_cyc[n_acc] = cyc; acc_id[n_acc] = 1'b1; n_acc++; end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("fair_count", n_acc, 4);
        for (int i = 0; i < n_acc; i++) begin
            check($sformatf("fair_id%0d", i), acc_id[i], i % 2);
            if (i > 0) check($sformatf("fair_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], W + 2);
        end
        for (int i = 0; i < 30 && bus.busy; i++) @(negedge clk);
        bus.res_ready = 1'b0;
        check("fair_drain", bus.busy, 0);

        // Backpressure: result held while a competing request waits.
        set_req(1'b0, 3'd5, 8'h3C, 8'h96);
        wait_accept(gid, ok);
        bus.req0_valid = 1'b0;
        set_req(1'b1, 3'd1, 8'h41, 8'h14);
        wait_result(lat);
        hold = bus.res_data;
        check("bp_first_data", hold, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", bus.res_valid, 1);
            check("bp_data", bus.res_data, hold);
            check("bp_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
            check("bp_busy", bus.busy, 1);
            @(negedge clk);
        end
        take_result();
        #1;
        check("bp_release_valid", bus.res_valid, 0);
        check("bp_release_ready1", bus.req1_ready, 1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        check("bp_second_busy", bus.busy, 1);
        wait_result(lat);
        check("bp_second_data", bus.res_data, 8'h55);
        check("bp_second_id", bus.res_id, 1);
        take_result();

        // Reset during EXEC at cnt == 3 aborts the request.
        set_req(1'b1, 3'd7, 8'hFF, 8'hFF);
        wait_accept(gid, ok);
        bus.req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_res_data", bus.res_data, 0);
        check("abort_res_id", bus.res_id, 0);
        check("abort_res_err", bus.res_err, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 0);
        do_txn("post_abort", '{1'b0, 3'd1, 8'h01, 8'h80, 8'h81, 1'b0});

        // Randomized traffic against the word-level model.
        do_reset();
        last = 1'b1;
        for (int t = 0; t < 40; t++) begin
            v   = $urandom_range(1, 3);
            op0 = 3'($urandom); a0 = W'($urandom); b0 = W'($urandom);
            op1 = 3'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            if (v[0]) set_req(1'b0, op0, a0, b0);
            if (v[1]) set_req(1'b1, op1, a1, b1);
            exp_id = (v == 3) ? ~last : (v == 2);
            wop = exp_id ? op1 : op0;
            wa  = exp_id ? a1  : a0;
            wb  = exp_id ? b1  : b0;
            wait_accept(gid, ok);
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            check("rnd_grant", gid, exp_id);
            wait_result(lat);
            check("rnd_latency", lat, W);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rnd_data", bus.res_data, ref_gate(wop, wa, wb));
            check("rnd_id", bus.res_id, exp_id);
            check("rnd_err", bus.res_err, (wop == 3'd7));
            take_result();
            last = exp_id;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_gate_scheduler.md
# mux_gate_scheduler

Shares a single bit-serial, 2:1-mux-based logic-gate evaluator between two requesters. Each request carries two WIDTH-bit operands and a 3-bit gate opcode. The block arbitrates round-robin and evaluates one bit per cycle, LSB first, through the shared mux stage. It returns the result with the winning requester's ID over a valid/ready result port. It sits between the mux-gate datapath and any client needing occasional multi-bit logic operations.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle when high with valid
- req0_op  input  3  opcode: 0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal
- req0_a / req0_b  input  WIDTH  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_data  output  WIDTH  result
- res_id  output  1  requester that issued the result
- res_err  output  1  opcode was 7
- busy  output  1  high whenever state ≠ IDLE

## Operation
- FSM states:
  - IDLE: on handshake, capture op, A, B and ID, clear bit counter, go to EXEC.
  - EXEC: evaluate bit[cnt] through one mux and write it into res_data[cnt]. Go to DONE when cnt == WIDTH-1; otherwise increment cnt.
  - DONE: hold res_valid. On res_ready, go to IDLE.
- Handshake:
  - reqN_ready = (state==IDLE) && grant==N. It is combinational from the valid inputs.
  - At most one ready is high per cycle. Both readys are low outside IDLE.
- Arbitration:
  - If only one valid is high, that requester is granted.
  - If both are valid, grant the requester not served last (last_id).
  - After reset, last_id = 1, so requester 0 wins the first tie.
  - last_id updates on accept.
- Mux mapping per bit (sel, i0, i1):
  - AND: (b, 0, a)
  - OR: (b, a, 1)
  - NOT: (a, 1, 0)
  - NAND: (a, 1, ~b)
  - NOR: (a, ~b, 0)
  - XOR: (a, b, ~b)
  - XNOR: (a, ~b, b)
- Exactly one mux evaluation per EXEC cycle.
- Op 7: EXEC still runs WIDTH cycles, each bit evaluates to 0, so res_data = 0 and res_err = 1.
- Result hold: res_data, res_id and res_err hold stable from DONE entry until the result handshake. Operands change only on accept.
- Requests are non-preemptible. A valid arriving during EXEC or DONE waits; it is never dropped while valid is held.

## Timing
- Reset values: res_valid 0, res_data 0, res_id 0, res_err 0, busy 0, both readys 0. State IDLE, cnt 0, last_id 1.
- rst has priority over all other events. rst during EXEC or DONE aborts the operation: the result is never presented, and the state returns to IDLE on the next edge.
- Accept at edge T, where valid & ready are high in the cycle before T.
  - EXEC occupies cycles T..T+WIDTH-1.
  - res_valid is high from T+WIDTH.
- If res_ready is high in the first DONE cycle, state is IDLE on the next edge. The next accept is then possible in that IDLE cycle.
- Minimum spacing between accepts is WIDTH+2 cycles.
- res_ready is ignored when res_valid is low.
- Requester valid/op/operand changes while not accepted have no effect.

## Test plan
- Single AND, WIDTH=8: req0 op0, A=0xF0, B=0x3C, accepted at T -> res_valid at T+8, res_data=0x30, res_id=0, res_err=0.
- Op sweep on req1, each expecting res_id=1:
  - XOR 0xA5,0xFF -> 0x5A
  - NOT 0xA5 -> 0x5A
  - XNOR 0xA5,0x0F -> 0x55
  - NAND 0xFF,0x0F -> 0xF0
  - NOR 0x0F,0x30 -> 0xC0
  - OR 0x0F,0x30 -> 0x3F
- Fairness: both valid continuously from reset, res_ready held high -> res_id sequence 0,1,0,1. Accepts are exactly WIDTH+2 cycles apart.
- Backpressure: res_ready low for 5 cycles in DONE -> res_valid stays 1, res_data stable, both readys 0, busy 1. Accept occurs only after the res_ready handshake.
- Reset mid-EXEC: assert rst at cnt=3 -> next edge gives all outputs at reset values and no res_valid for that request. A subsequent req0 OR 0x01,0x80 returns 0x81.
- Illegal op: req0 op7, A=0xFF, B=0xFF -> res_data=0x00, res_err=1, same latency as a legal op.
